inst_decode_queue: RTL and testbench

//  Registered RV32/RV64 instruction decode stage with an output queue. Accepts fetched

---
 rtl/inst_decode_queue_pkg.sv | 75 +++++++
 rtl/inst_decode_queue_if.sv | 40 ++++
 rtl/inst_decode_queue_field_decode.sv | 82 ++++++++
 rtl/inst_decode_queue.sv | 103 ++++++++++
 tb/tb_inst_decode_queue.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_decode_queue_pkg.sv
// Shared types for the instruction decode queue.
//  - RV32/RV64 base opcodes (OPC_*)
//  - opclass_t: coarse instruction class handed to issue
//  - dec_t: one decoded queue entry; PC and immediate are carried at MAX_XLEN
//    and trimmed to the configured XLEN at the queue output
//  - imm_* helpers: per-format immediates, sign-extended from INSTR[31]
package leve_inst_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        CL_LUI     = 4'd0,
        CL_AUIPC   = 4'd1,
        CL_JAL     = 4'd2,
        CL_JALR    = 4'd3,
        CL_BRANCH  = 4'd4,
        CL_LOAD    = 4'd5,
        CL_STORE   = 4'd6,
        CL_OPIMM   = 4'd7,
        CL_OP      = 4'd8,
        CL_MULDIV  = 4'd9,
        CL_CSR     = 4'd10,
        CL_ECALL   = 4'd11,
        CL_EBREAK  = 4'd12,
        CL_MRET    = 4'd13,
        CL_FENCE   = 4'd14,
        CL_ILLEGAL = 4'd15
    } opclass_t;

    typedef struct packed {
        opclass_t              opclass;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [11:0]           csr;
        logic [MAX_XLEN-1:0]   imm;
        logic                  illegal;
        logic [MAX_XLEN-1:0]   pc;
    } dec_t;

    function automatic logic [MAX_XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [MAX_XLEN-1:0] imm_s(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [MAX_XLEN-1:0] imm_b(input logic [31:0] instr);
        return {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [MAX_XLEN-1:0] imm_u(input logic [31:0] instr);
        return {{32{instr[31]}}, instr[31:12], 12'b0};
    endfunction

    function automatic logic [MAX_XLEN-1:0] imm_j(input logic [31:0] instr);
        return {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_decode_queue_if.sv
// Handshake bundle between fetch (producer), the decode queue and issue (consumer).
//  master : the environment around the queue (drives IN_*, FLUSH, OUT_READY)
//  slave  : the decode queue itself (drives IN_READY and all OUT_*)
// Parameter XLEN sets the PC and immediate width.
interface inst_decode_queue_if #(
    parameter int XLEN = 64
);
    import leve_inst_pkg::*;

    logic              FLUSH;
    logic              IN_VALID;
    logic              IN_READY;
    logic [31:0]       IN_INSTR;
    logic [XLEN-1:0]   IN_PC;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [XLEN-1:0]   OUT_PC;
    opclass_t          OUT_CLASS;
    logic [4:0]        OUT_RD;
    logic [4:0]        OUT_RS1;
    logic [4:0]        OUT_RS2;
    logic [2:0]        OUT_FUNCT3;
    logic [6:0]        OUT_FUNCT7;
    logic [11:0]       OUT_CSR;
    logic [XLEN-1:0]   OUT_IMM;
    logic              OUT_ILLEGAL;

    modport master (
        output FLUSH, IN_VALID, IN_INSTR, IN_PC, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_PC, OUT_CLASS, OUT_RD, OUT_RS1, OUT_RS2,
               OUT_FUNCT3, OUT_FUNCT7, OUT_CSR, OUT_IMM, OUT_ILLEGAL
    );

    modport slave (
        input  FLUSH, IN_VALID, IN_INSTR, IN_PC, OUT_READY,
        output IN_READY, OUT_VALID, OUT_PC, OUT_CLASS, OUT_RD, OUT_RS1, OUT_RS2,
               OUT_FUNCT3, OUT_FUNCT7, OUT_CSR, OUT_IMM, OUT_ILLEGAL
    );

endinterface

// File: rtl/inst_decode_queue_field_decode.sv
// inst_field_decode: purely combinational RV32/RV64 field decoder.
//  instr : 32-bit instruction word
//  dec   : decoded fields, class and sign-extended immediate (pc left 0;
//          the queue fills it in)
// Optional feature macro: LEVE_INST_DEC_M_EN -- when defined, OP with
// funct7=0000001 decodes as CL_MULDIV; otherwise it is CL_ILLEGAL.
module inst_field_decode
    import leve_inst_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    // Field extraction, classification and immediate selection.
    always_comb begin
        dec         = '0;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = instr[14:12];
        dec.funct7  = instr[31:25];
        dec.csr     = instr[31:20];
        dec.pc      = 64'd0;
        dec.imm     = 64'd0;
        dec.opclass = CL_ILLEGAL;

        // Compressed or reserved encodings never reach the base-ISA table.
        if (instr[1:0] != 2'b11) begin
            dec.opclass = CL_ILLEGAL;
        end else begin
            case (instr[6:0])
                OPC_LUI:      begin dec.opclass = CL_LUI;    dec.imm = imm_u(instr); end
                OPC_AUIPC:    begin dec.opclass = CL_AUIPC;  dec.imm = imm_u(instr); end
                OPC_JAL:      begin dec.opclass = CL_JAL;    dec.imm = imm_j(instr); end
                OPC_JALR:     begin dec.opclass = CL_JALR;   dec.imm = imm_i(instr); end
                OPC_BRANCH:   begin dec.opclass = CL_BRANCH; dec.imm = imm_b(instr); end
                OPC_LOAD:     begin dec.opclass = CL_LOAD;   dec.imm = imm_i(instr); end
                OPC_STORE:    begin dec.opclass = CL_STORE;  dec.imm = imm_s(instr); end
                OPC_OPIMM:    begin dec.opclass = CL_OPIMM;  dec.imm = imm_i(instr); end
                OPC_MISC_MEM: begin dec.opclass = CL_FENCE;  dec.imm = imm_i(instr); end
                OPC_OP: begin
                    // Register-register ops carry no immediate.
                    if (instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000) begin
                        dec.opclass = CL_OP;
`ifdef LEVE_INST_DEC_M_EN
                    end else if (instr[31:25] == 7'b0000001) begin
                        dec.opclass = CL_MULDIV;
`endif
                    end else begin
                        dec.opclass = CL_ILLEGAL;
                    end
                end
                OPC_SYSTEM: begin
                    if (instr[14:12] != 3'b000) begin
                        // CSR ops: immediate slot carries the 5-bit uimm, zero-extended.
                        dec.opclass = CL_CSR;
                        dec.imm     = {59'd0, instr[19:15]};
                    end else if (instr == 32'h0000_0073) begin
                        dec.opclass = CL_ECALL;
                    end else if (instr == 32'h0010_0073) begin
                        dec.opclass = CL_EBREAK;
                    end else if (instr[31:25] == 7'b0011000 && instr[24:20] == 5'b00010 &&
                                 instr[19:15] == 5'd0 && instr[11:7] == 5'd0) begin
                        dec.opclass = CL_MRET;
                    end else begin
                        dec.opclass = CL_ILLEGAL;
                    end
                end
                default: dec.opclass = CL_ILLEGAL;
            endcase
        end

        // Unrecognised words are flagged and never carry an immediate.
        if (dec.opclass == CL_ILLEGAL) begin
            dec.illegal = 1'b1;
            dec.imm     = 64'd0;
        end else begin
            dec.illegal = 1'b0;
        end
    end

endmodule

// File: rtl/inst_decode_queue.sv
// inst_decode_queue: registered decode stage with a DEPTH-entry output queue.
//  CLK  : clock, rising edge
//  RSTn : synchronous active-low reset (empties the queue like FLUSH)
//  bus  : inst_decode_queue_if.slave -- IN_* push side from fetch, OUT_* pop
//         side towards issue, FLUSH drops everything including a same-cycle push
// Parameters: XLEN (32/64) PC/immediate width, DEPTH (power of two, >= 2).
// Optional feature macro: LEVE_INST_DEC_M_EN (enables CL_MULDIV in the decoder).
// IN_READY / OUT_VALID come from the registered count only; the head payload is
// read from the entry at rd_ptr, so it stays put while the consumer stalls.
module inst_decode_queue
    import leve_inst_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
)(
    input  logic                  CLK,
    input  logic                  RSTn,
    inst_decode_queue_if.slave    bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    dec_t              dec_s;
    dec_t              entry_s;
    dec_t              head_s;
    dec_t              mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              push_s;
    logic              pop_s;

    inst_field_decode u_decode (
        .instr (bus.IN_INSTR),
        .dec   (dec_s)
    );

    assign in_ready_s  = (count_r != FULL_CNT);
    assign out_valid_s = (count_r != {CNT_W{1'b0}});
    // A flushed cycle accepts nothing, so FLUSH also masks push and pop.
    assign push_s = bus.IN_VALID  && in_ready_s  && !bus.FLUSH;
    assign pop_s  = bus.OUT_READY && out_valid_s && !bus.FLUSH;

    // Attach the instruction address to the decoded fields.
    always_comb begin
        entry_s    = dec_s;
        entry_s.pc = MAX_XLEN'(bus.IN_PC);
    end

    // Queue bookkeeping: pointers and occupancy; reset and flush empty the queue.
    always_ff @(posedge CLK) begin
        if (!RSTn || bus.FLUSH) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; deliberately not reset, validity lives in count_r.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    assign head_s = mem_r[rd_ptr_r];

    assign bus.IN_READY    = in_ready_s;
    assign bus.OUT_VALID   = out_valid_s;
    assign bus.OUT_PC      = head_s.pc[XLEN-1:0];
    assign bus.OUT_CLASS   = head_s.opclass;
    assign bus.OUT_RD      = head_s.rd;
    assign bus.OUT_RS1     = head_s.rs1;
    assign bus.OUT_RS2     = head_s.rs2;
    assign bus.OUT_FUNCT3  = head_s.funct3;
    assign bus.OUT_FUNCT7  = head_s.funct7;
    assign bus.OUT_CSR     = head_s.csr;
    assign bus.OUT_IMM     = head_s.imm[XLEN-1:0];
    assign bus.OUT_ILLEGAL = head_s.illegal;

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed self-checking bench for inst_decode_queue (XLEN=64, DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_inst_decode_queue;
    import leve_inst_pkg::*;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    inst_decode_queue_if #(.XLEN(XLEN)) bus ();

    inst_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // beq -4, mret, all-zero word, lui x2 0x12345, sw x1 8(x2), csrrs x5 mstatus x31
    localparam logic [31:0] DEC_INSTR [6] = '{32'hFE000EE3, 32'h30200073, 32'h00000000,
                                              32'h12345137, 32'h00112423, 32'h300FA2F3};
    localparam opclass_t    DEC_CLASS [6] = '{CL_BRANCH, CL_MRET, CL_ILLEGAL,
                                              CL_LUI, CL_STORE, CL_CSR};
    localparam logic        DEC_ILL   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [4:0]  DEC_RD    [6] = '{5'd29, 5'd0, 5'd0, 5'd2, 5'd8, 5'd5};
    localparam logic [11:0] DEC_CSR   [6] = '{12'hFE0, 12'h302, 12'h000, 12'h123, 12'h001, 12'h300};
    localparam logic [63:0] DEC_IMM   [6] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0,
                                              64'h0000_0000_1234_5000, 64'd8, 64'd31};

    // addi x(k+1), x0, k
    function automatic logic [31:0] mk_addi(input int k);
        return {12'(k), 5'd0, 3'b000, 5'(k + 1), 7'b0010011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [63:0] pc);
        bus.IN_VALID = 1'b1;
        bus.IN_INSTR = instr;
        bus.IN_PC    = pc;
        tick();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.IN_READY);
        end
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_opimm();
        bus.OUT_READY = 1'b1;
        push_one(32'hFFF00093, 64'h0000_0000_8000_0000);
        checks++;
        if (bus.OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL opimm_valid: got %b expected 1", bus.OUT_VALID);
        end
        checks++;
        if (bus.OUT_CLASS !== CL_OPIMM) begin
            errors++; $display("FAIL opimm_class: got %0d expected %0d", bus.OUT_CLASS, CL_OPIMM);
        end
        checks++;
        if (bus.OUT_RD !== 5'd1 || bus.OUT_RS1 !== 5'd0) begin
            errors++; $display("FAIL opimm_regs: got rd=%0d rs1=%0d expected rd=1 rs1=0", bus.OUT_RD, bus.OUT_RS1);
        end
        checks++;
        if (bus.OUT_IMM !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL opimm_imm: got %h expected ffffffffffffffff", bus.OUT_IMM);
        end
        checks++;
        if (bus.OUT_PC !== 64'h0000_0000_8000_0000 || bus.OUT_ILLEGAL !== 1'b0) begin
            errors++; $display("FAIL opimm_pc: got pc=%h ill=%b expected pc=80000000 ill=0", bus.OUT_PC, bus.OUT_ILLEGAL);
        end
        tick();
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL opimm_drained: got %b expected 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_decode();
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_one(DEC_INSTR[i], 64'h100 + 64'(i * 4));
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_PC !== 64'h100 + 64'(i * 4)) begin
                errors++; $display("FAIL dec%0d_head: got valid=%b pc=%h", i, bus.OUT_VALID, bus.OUT_PC);
            end
            checks++;
            if (bus.OUT_CLASS !== DEC_CLASS[i] || bus.OUT_ILLEGAL !== DEC_ILL[i]) begin
                errors++; $display("FAIL dec%0d_class: got %0d/%b expected %0d/%b", i,
                                   bus.OUT_CLASS, bus.OUT_ILLEGAL, DEC_CLASS[i], DEC_ILL[i]);
            end
            checks++;
            if (bus.OUT_RD !== DEC_RD[i] || bus.OUT_CSR !== DEC_CSR[i]) begin
                errors++; $display("FAIL dec%0d_fields: got rd=%0d csr=%h expected rd=%0d csr=%h", i,
                                   bus.OUT_RD, bus.OUT_CSR, DEC_RD[i], DEC_CSR[i]);
            end
            checks++;
            if (bus.OUT_IMM !== DEC_IMM[i]) begin
                errors++; $display("FAIL dec%0d_imm: got %h expected %h", i, bus.OUT_IMM, DEC_IMM[i]);
            end
        end
        tick();
    endtask

    task automatic test_muldiv();
        opclass_t exp_cls;
        logic     exp_ill;
`ifdef LEVE_INST_DEC_M_EN
        exp_cls = CL_MULDIV;
        exp_ill = 1'b0;
`else
        exp_cls = CL_ILLEGAL;
        exp_ill = 1'b1;
`endif
        bus.OUT_READY = 1'b1;
        push_one(32'h022081B3, 64'h200);
        checks++;
        if (bus.OUT_CLASS !== exp_cls || bus.OUT_ILLEGAL !== exp_ill) begin
            errors++; $display("FAIL muldiv_class: got %0d/%b expected %0d/%b",
                               bus.OUT_CLASS, bus.OUT_ILLEGAL, exp_cls, exp_ill);
        end
        checks++;
        if (bus.OUT_RD !== 5'd3 || bus.OUT_RS1 !== 5'd1 || bus.OUT_RS2 !== 5'd2 || bus.OUT_FUNCT7 !== 7'b0000001) begin
            errors++; $display("FAIL muldiv_fields: got rd=%0d rs1=%0d rs2=%0d f7=%b expected 3 1 2 0000001",
                               bus.OUT_RD, bus.OUT_RS1, bus.OUT_RS2, bus.OUT_FUNCT7);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.OUT_READY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.IN_READY !== 1'b1) begin
                errors++; $display("FAIL fill%0d_ready: got %b expected 1", k, bus.IN_READY);
            end
            push_one(mk_addi(k), 64'h2000 + 64'(k * 4));
        end
        // Fifth word presented while full; must be held.
        bus.IN_VALID = 1'b1;
        bus.IN_INSTR = mk_addi(4);
        bus.IN_PC    = 64'h2010;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b1 || bus.OUT_PC !== 64'h2000) begin
                errors++; $display("FAIL full%0d: got ready=%b valid=%b pc=%h expected 0 1 2000",
                                   c, bus.IN_READY, bus.OUT_VALID, bus.OUT_PC);
            end
            tick();
        end
        bus.OUT_READY = 1'b1;
        tick();
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_after_pop: got %b expected 1", bus.IN_READY);
        end
        // Fifth word is accepted at the next edge, alongside the second pop.
        for (int e = 1; e < 5; e++) begin
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_PC !== 64'h2000 + 64'(e * 4) || bus.OUT_RD !== 5'(e + 1)) begin
                errors++; $display("FAIL b2b_order%0d: got valid=%b pc=%h rd=%0d expected 1 %h %0d", e,
                                   bus.OUT_VALID, bus.OUT_PC, bus.OUT_RD, 64'h2000 + 64'(e * 4), e + 1);
            end
            tick();
            bus.IN_VALID = 1'b0;
        end
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL b2b_empty: got %b expected 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_flush();
        bus.OUT_READY = 1'b0;
        for (int k = 0; k < 3; k++) push_one(mk_addi(k), 64'h3000 + 64'(k * 4));
        bus.FLUSH    = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.IN_INSTR = mk_addi(9);
        bus.IN_PC    = 64'hDEAD;
        tick();
        bus.FLUSH    = 1'b0;
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL flush_state: got valid=%b ready=%b expected 0 1", bus.OUT_VALID, bus.IN_READY);
        end
        tick();
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL flush_no_ghost: got %b expected 0", bus.OUT_VALID);
        end
        push_one(mk_addi(5), 64'h4000);
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_PC !== 64'h4000) begin
            errors++; $display("FAIL flush_repush: got valid=%b pc=%h expected 1 4000", bus.OUT_VALID, bus.OUT_PC);
        end
        bus.OUT_READY = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        logic [63:0] q [$];
        logic [63:0] cur_pc;
        int  sent;
        int  got;
        int  cyc;
        logic rdy;
        logic do_push;
        logic do_pop;
        sent = 0; got = 0; cyc = 0; rdy = 1'b0;
        while (got < 3 * DEPTH && cyc < 100) begin
            cur_pc        = 64'h5000 + 64'(sent * 4);
            bus.OUT_READY = rdy;
            bus.IN_VALID  = (sent < 3 * DEPTH);
            bus.IN_INSTR  = mk_addi(sent);
            bus.IN_PC     = cur_pc;
            checks++;
            if (bus.IN_READY !== (q.size() != DEPTH) || bus.OUT_VALID !== (q.size() != 0)) begin
                errors++; $display("FAIL wrap_flags c%0d: got ready=%b valid=%b model count %0d",
                                   cyc, bus.IN_READY, bus.OUT_VALID, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (bus.OUT_PC !== q[0]) begin
                    errors++; $display("FAIL wrap_order c%0d: got %h expected %h", cyc, bus.OUT_PC, q[0]);
                end
            end
            do_push = (sent < 3 * DEPTH) && (q.size() != DEPTH);
            do_pop  = rdy && (q.size() != 0);
            tick();
            if (do_pop) begin
                void'(q.pop_front());
                got++;
            end
            if (do_push) begin
                q.push_back(cur_pc);
                sent++;
            end
            rdy = !rdy;
            cyc++;
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if (got != 3 * DEPTH) begin
            errors++; $display("FAIL wrap_timeout: got %0d entries expected %0d", got, 3 * DEPTH);
        end
        // Reset in the middle of a stream with a push pending.
        bus.OUT_READY = 1'b0;
        push_one(mk_addi(1), 64'h6000);
        push_one(mk_addi(2), 64'h6004);
        rstn         = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.IN_PC    = 64'h6008;
        tick();
        rstn         = 1'b1;
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL midreset_state: got valid=%b ready=%b expected 0 1", bus.OUT_VALID, bus.IN_READY);
        end
        tick();
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL midreset_hold: got %b expected 0", bus.OUT_VALID);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rstn          = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_INSTR  = 32'd0;
        bus.IN_PC     = 64'd0;
        bus.OUT_READY = 1'b0;
        test_reset();
        test_opimm();
        test_decode();
        test_muldiv();
        test_back_to_back();
        test_flush();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
